load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Parametrised load-data alignment unit between the core's load path and a word-wide data memory. It accepts a byte, halfword or word load request at any byte address and issues one or two aligned memory reads. It extracts the addressed bytes and returns them sign- or zero-extended to DATA_W. It generalises the fixed 32-bit combinational byte selector with variable width, access size, sign extension and misaligned (word-straddling) access.

Parameters:
DATA_W, 32, memory word and result width; power of two, >= 16.
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  load request present
req_ready  out  1  unit can accept a request
req_addr  in  ADDR_W  byte address
req_size  in  2  log2(bytes): 0=byte, 1=half, 2=word, 3=dword
req_signed  in  1  1=sign-extend, 0=zero-extend
mem_req  out  1  one-cycle memory read strobe
mem_addr  out  ADDR_W  word-aligned read address (low log2(DATA_W/8) bits zero)
mem_rvalid  in  1  read data valid, >=1 cycle after mem_req
mem_rdata  in  DATA_W  read data
rsp_valid  out  1  one-cycle result strobe
rsp_data  out  DATA_W  extended result; held until next rsp_valid
rsp_err  out  1  error flag, qualified by rsp_valid

Behaviour:
- Reset: state IDLE. req_ready=1. mem_req=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0. Internal word buffers cleared.
- Reset mid-operation aborts the access. A mem_rvalid arriving after reset release while in IDLE is ignored.
- Request handshake: accept when req_valid && req_ready. req_ready=1 only in IDLE. On acceptance, addr, size and signed are registered.
- Definitions: B = DATA_W/8 and off = addr mod B. Bytes: n = 2^size.
- Misaligned: off + n > B.
- Size error: n > B. It gives rsp_err=1 and rsp_data=0, with no memory access. The response comes via RESP one cycle after acceptance.
- States: IDLE -> REQ0 -> WAIT0 -> (REQ1 -> WAIT1 if misaligned) -> RESP -> IDLE.
- REQ0: mem_req=1 for one cycle. mem_addr = addr with low bits cleared.
- REQ1: mem_req=1 for one cycle. mem_addr = aligned addr + B, wrapping mod 2^ADDR_W.
- WAITx: capture mem_rdata into word0/word1 on mem_rvalid. mem_rvalid outside WAITx is ignored.
- RESP: rsp_valid=1 for one cycle, then IDLE. There is no response back-pressure.
- Extraction: take {word1, word0} >> (8*off), and keep the low 8*n bits.
  - Bit 8*n-1 is replicated upward if req_signed, otherwise zeros.
  - n = B gives no extension.
- Latency, aligned, memory latency 1: accept at t0, mem_req at t1, mem_rvalid at t2, rsp_valid at t3.
- Latency, misaligned: rsp_valid at t5.
- rsp_err=0 for all completed legal accesses.

Optional Feature:
Macro LOAD_MISALIGN_TRAP_EN.
- Defined: a misaligned legal-size request issues no memory read. It goes IDLE -> RESP and responds with rsp_err=1, rsp_data=0.
- Undefined: misaligned requests are split into two reads as above. REQ1/WAIT1 exist only in this build.

Test Plan:
All scenarios use DATA_W=32, mem[0x100]=0xF3E2D1C0, mem[0x104]=0x07060504, memory latency 1.
1. Byte loads at 0x101: signed gives rsp_data=0xFFFFFFD1, unsigned gives 0x000000D1. One mem_req with mem_addr=0x100, rsp_valid 3 cycles after accept, rsp_err=0.
2. Halfword signed at 0x102 gives rsp_data=0xFFFFF3E2. Halfword unsigned at 0x100 gives 0x0000D1C0.
3. Word at 0x103:
   - Trap undefined: two mem_req (0x100, then 0x104) and rsp_data=0x060504F3 at t5.
   - LOAD_MISALIGN_TRAP_EN defined: no mem_req, rsp_err=1, rsp_data=0.
4. size=3 at 0x100 gives rsp_err=1, rsp_data=0, no mem_req. Next request is accepted normally.
5. Word at 0xFFFFFFFE, trap undefined: mem_addr sequence 0xFFFFFFFC then 0x00000000 (wrap). Result = upper half of first word, lower half of second.
6. Assert rst during WAIT0: all outputs read 0 and req_ready=1 immediately. A late mem_rvalid produces no rsp_valid. A subsequent byte load at 0x100 returns 0x000000C0.

Source files
------------

// File: rtl/load_align_unit.sv
// Load alignment unit: one or two word reads per load, byte extraction and sign/zero extension.
// Build option LOAD_MISALIGN_TRAP_EN: word-straddling loads return an error instead of a second read.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(B);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
`ifndef LOAD_MISALIGN_TRAP_EN
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
`endif
    S_RESP  = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              misal_q, misal_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] word0_q, word0_d;
  logic [DATA_W-1:0] word1_q, word1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              accept;
  logic [31:0]       req_bits;
  logic [31:0]       req_off_bits;
  logic              req_size_err;
  logic              req_misal;
  logic              req_trap;
  logic [DATA_W-1:0] result_w;

  // Shift the two-word window down to the addressed byte, then mask/extend to the access width.
  function automatic logic [DATA_W-1:0] extract(
    input logic [2*DATA_W-1:0] pair,
    input logic [OFF_W-1:0]    off,
    input logic [1:0]          size,
    input logic                sgn
  );
    logic [2*DATA_W-1:0] shifted;
    logic [DATA_W-1:0]   low;
    logic [DATA_W-1:0]   keep;
    logic [DATA_W-1:0]   top;
    logic [31:0]         nbits;
    shifted = pair >> {off, 3'b000};
    low     = shifted[DATA_W-1:0];
    nbits   = 32'd8 << size;
    keep    = ~({DATA_W{1'b1}} << nbits);
    top     = keep ^ (keep >> 1);
    if (sgn && ((low & top) != '0)) begin
      return (low & keep) | ~keep;
    end
    return low & keep;
  endfunction

  assign accept       = req_valid && (state_q == S_IDLE);
  assign req_bits     = 32'd8 << req_size;
  assign req_off_bits = 32'(req_addr[OFF_W-1:0]) << 3;
  assign req_size_err = req_bits > 32'(DATA_W);
  assign req_misal    = (req_off_bits + req_bits) > 32'(DATA_W);

`ifdef LOAD_MISALIGN_TRAP_EN
  assign req_trap = req_misal;
`else
  assign req_trap = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_size_err || req_trap) begin
            state_d = S_RESP;
          end else begin
            state_d = S_REQ0;
          end
        end
      end
      S_REQ0:  state_d = S_WAIT0;
      S_WAIT0: begin
        if (mem_rvalid) begin
`ifndef LOAD_MISALIGN_TRAP_EN
          state_d = misal_q ? S_REQ1 : S_RESP;
`else
          state_d = S_RESP;
`endif
        end
      end
`ifndef LOAD_MISALIGN_TRAP_EN
      S_REQ1:  state_d = S_WAIT1;
      S_WAIT1: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
        end
      end
`endif
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_REQ0: mem_req   = 1'b1;
`ifndef LOAD_MISALIGN_TRAP_EN
      S_REQ1: mem_req   = 1'b1;
`endif
      S_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Error responses never touched memory, so the buffers are irrelevant to them.
  assign result_w = err_q ? '0 : extract({word1_q, word0_q}, off_q, size_q, signed_q);

  always_comb begin
    off_d      = off_q;
    size_d     = size_q;
    signed_d   = signed_q;
    misal_d    = misal_q;
    err_d      = err_q;
    word0_d    = word0_q;
    word1_d    = word1_q;
    mem_addr_d = mem_addr_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d    = req_addr[OFF_W-1:0];
          size_d   = req_size;
          signed_d = req_signed;
          misal_d  = req_misal;
          err_d    = req_size_err || req_trap;
          word0_d  = '0;
          word1_d  = '0;
          if (!(req_size_err || req_trap)) begin
            mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
      end
      S_WAIT0: begin
        if (mem_rvalid) begin
          word0_d = mem_rdata;
`ifndef LOAD_MISALIGN_TRAP_EN
          if (misal_q) begin
            mem_addr_d = mem_addr_q + WORD_STEP;
          end
`endif
        end
      end
`ifndef LOAD_MISALIGN_TRAP_EN
      S_WAIT1: begin
        if (mem_rvalid) begin
          word1_d = mem_rdata;
        end
      end
`endif
      S_RESP: rsp_data_d = result_w;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q      <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      misal_q    <= 1'b0;
      err_q      <= 1'b0;
      word0_q    <= '0;
      word1_q    <= '0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
    end else begin
      off_q      <= off_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      misal_q    <= misal_d;
      err_q      <= err_d;
      word0_q    <= word0_d;
      word1_q    <= word1_d;
      mem_addr_q <= mem_addr_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // The fresh result is driven during RESP; afterwards the registered copy holds it.
  assign mem_addr = mem_addr_q;
  assign rsp_data = rsp_valid ? result_w : rsp_data_q;
  assign rsp_err  = rsp_valid & err_q;

  a_no_overlap: assert property (@(posedge clk) disable iff (rst) mem_req |-> !rsp_valid);

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: byte-level memory model, directed plan cases and random loads.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          mem_lat = 1;
  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] last_rsp = '0;
  exp_t        cur;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h100) return 32'hF3E2D1C0;
    if (a == 32'h104) return 32'h07060504;
    return (a * 32'h9E3779B1) ^ 32'hA5C31E77;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic bit is_misal(input logic [31:0] a, input logic [1:0] sz);
    return (int'(a[1:0]) + (1 << sz)) > 4;
  endfunction

  // Number of memory reads a load must cause.
  function automatic int reads(input logic [31:0] a, input logic [1:0] sz);
    if ((1 << sz) > 4) return 0;
`ifdef LOAD_MISALIGN_TRAP_EN
    if (is_misal(a, sz)) return 0;
    return 1;
`else
    return is_misal(a, sz) ? 2 : 1;
`endif
  endfunction

  // Returns {err, data}: gather n bytes little-endian from the byte address, then extend.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    if (n > 4) return {1'b1, 32'h0};
`ifdef LOAD_MISALIGN_TRAP_EN
    if (is_misal(a, sz)) return {1'b1, 32'h0};
`endif
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return {1'b0, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory: answers each strobe mem_lat cycles later with the word at the strobed address.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req && !rst) begin
        logic [31:0] a;
        a = mem_addr;
        repeat (mem_lat) @(posedge clk);
        #1 mem_rvalid = 1'b1;
        mem_rdata = mem_word(a);
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
        mem_rdata = $urandom;
      end
    end
  end

  // Compare process: reads, responses and held result checked every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (addr_q.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hXXXXXXXX);
        else chk("mem_addr", mem_addr, addr_q.pop_front());
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_data, 32'hXXXXXXXX);
        end else begin
          cur = exp_q.pop_front();
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_err", 32'(rsp_err), 32'(cur.err));
          chk("rsp_cycle", 32'(cyc), 32'(cur.cyc));
          chk("reads_outstanding", 32'(addr_q.size()), 32'd0);
        end
        last_rsp = rsp_data;
      end else begin
        chk("rsp_hold", rsp_data, last_rsp);
      end
    end
  end

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sg, input int lat,
                      input bit use_lit, input logic [31:0] lit_d, input logic lit_e);
    logic [32:0] m;
    exp_t        e;
    int          nr;
    int          waited;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    m  = model(a, sz, sg);
    nr = reads(a, sz);
    if (use_lit) begin
      chk("model_pin_data", m[31:0], lit_d);
      chk("model_pin_err", 32'(m[32]), 32'(lit_e));
      e.data = lit_d;
      e.err  = lit_e;
    end else begin
      e.data = m[31:0];
      e.err  = m[32];
    end
    e.cyc = cyc + ((nr == 0) ? 1 : (nr == 1) ? 2 + lat : 3 + 2 * lat);
    if (nr >= 1) addr_q.push_back({a[31:2], 2'b00});
    if (nr == 2) addr_q.push_back({a[31:2], 2'b00} + 32'd4);
    exp_q.push_back(e);
    mem_lat    = lat;
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr = $urandom;
    req_size = 2'($urandom_range(0, 3));
    waited = 0;
    while (exp_q.size() != 0 && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) begin
      chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w_hi, w_lo;
    logic [1:0]  rsz;
    logic [31:0] ra;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    load(32'h101, 2'd0, 1'b1, 1, 1, 32'hFFFFFFD1, 1'b0);
    load(32'h101, 2'd0, 1'b0, 1, 1, 32'h000000D1, 1'b0);
    load(32'h102, 2'd1, 1'b1, 1, 1, 32'hFFFFF3E2, 1'b0);
    load(32'h100, 2'd1, 1'b0, 1, 1, 32'h0000D1C0, 1'b0);
`ifdef LOAD_MISALIGN_TRAP_EN
    load(32'h103, 2'd2, 1'b0, 1, 1, 32'h00000000, 1'b1);
`else
    load(32'h103, 2'd2, 1'b0, 1, 1, 32'h060504F3, 1'b0);
`endif
    load(32'h100, 2'd3, 1'b0, 1, 1, 32'h00000000, 1'b1);
    load(32'h100, 2'd0, 1'b0, 1, 1, 32'h000000C0, 1'b0);
    w_hi = mem_word(32'hFFFFFFFC);
    w_lo = mem_word(32'h00000000);
`ifdef LOAD_MISALIGN_TRAP_EN
    load(32'hFFFFFFFE, 2'd2, 1'b0, 1, 1, 32'h00000000, 1'b1);
`else
    load(32'hFFFFFFFE, 2'd2, 1'b0, 1, 1, {w_lo[15:0], w_hi[31:16]}, 1'b0);
`endif
    load(32'h104, 2'd2, 1'b1, 3, 1, 32'h07060504, 1'b0);

    // Reset while waiting for the first read; the late read data must be ignored.
    @(negedge clk);
    mem_lat    = 3;
    addr_q.push_back(32'h100);
    req_valid  = 1'b1;
    req_addr   = 32'h100;
    req_size   = 2'd2;
    req_signed = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    last_rsp = '0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", rsp_data, 32'd0);
    chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    load(32'h100, 2'd0, 1'b0, 1, 1, 32'h000000C0, 1'b0);

    for (int k = 0; k < 200; k++) begin
      case ($urandom_range(0, 9))
        0:       ra = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
        1:       ra = $urandom;
        default: ra = 32'h100 + 32'($urandom_range(0, 63));
      endcase
      rsz = 2'($urandom_range(0, 3));
      load(ra, rsz, 1'($urandom_range(0, 1)), $urandom_range(1, 3), 0, 32'h0, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
